// File: rtl/k16_mem_arbiter_pkg.sv
// Shared definitions for the K16 main-RAM arbiter: FSM state encoding and
// the helper used to size its saturating counters.
package k16_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_CPU    = 2'd0,
        ST_VID    = 2'd1,
        ST_RESUME = 2'd2,
        ST_GUARD  = 2'd3
    } arb_state_t;

    // Bits needed to hold 0..max_value inclusive, never less than one.
    function automatic int cnt_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/k16_mem_arbiter.sv
// Arbitrates the single-port main RAM between the K16 CPU and the video line
// fetcher. Video wins but is limited to bounded bursts; the CPU is stalled via hold.
module k16_mem_arbiter
    import k16_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16,
    parameter int MAX_VID_BURST = 8,
    parameter int CPU_GUARANTEE = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_data_out,
    input  logic              cpu_write,
    output logic              cpu_hold,
    output logic [DATA_W-1:0] cpu_data_in,
    input  logic              vid_req,
    input  logic              vid_last,
    input  logic [ADDR_W-1:0] vid_address,
    output logic              vid_ack,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_data_in
);

    localparam int BURST_W = cnt_width(MAX_VID_BURST);
    localparam int GUARD_W = cnt_width(CPU_GUARANTEE);

    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_VID_BURST - 1);
    localparam logic [BURST_W-1:0] BURST_SAT  = BURST_W'(MAX_VID_BURST);
    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(CPU_GUARANTEE - 1);
    localparam logic [GUARD_W-1:0] GUARD_SAT  = GUARD_W'(CPU_GUARANTEE);

    arb_state_t         state_reg;
    logic [BURST_W-1:0] burst_cnt_reg;
    logic [GUARD_W-1:0] guard_cnt_reg;
    logic               cut_reg;
    logic               cpu_hold_reg;
    logic               vid_valid_reg;

    logic               vid_more;
    logic               vid_continue;

    // Video still has words queued in this burst (not the last, request held).
    assign vid_more     = vid_req && !vid_last;
    assign vid_continue = vid_more && (burst_cnt_reg < BURST_LAST);

    // Read data is broadcast; the hold/valid qualifiers tell each side whose it is.
    assign cpu_data_in  = mem_data_in;
    assign vid_data     = mem_data_in;
    assign mem_data_out = cpu_data_out;
    assign cpu_hold     = cpu_hold_reg;
    assign vid_valid    = vid_valid_reg;

    always_comb begin
        mem_address = cpu_address;
        mem_write   = 1'b0;
        vid_ack     = 1'b0;
        unique case (state_reg)
            ST_CPU, ST_GUARD: mem_write = cpu_write;
            ST_VID: begin
                mem_address = vid_address;
                vid_ack     = vid_req;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_CPU;
            burst_cnt_reg <= '0;
            guard_cnt_reg <= '0;
            cut_reg       <= 1'b0;
            cpu_hold_reg  <= 1'b0;
            vid_valid_reg <= 1'b0;
        end else begin
            vid_valid_reg <= vid_ack;
            unique case (state_reg)
                ST_CPU: begin
                    if (vid_req) begin
                        state_reg     <= ST_VID;
                        burst_cnt_reg <= '0;
                        cpu_hold_reg  <= 1'b1;
                    end else begin
                        cpu_hold_reg  <= 1'b0;
                    end
                end
                ST_VID: begin
                    cpu_hold_reg <= 1'b1;
                    if (vid_continue) begin
                        burst_cnt_reg <= (burst_cnt_reg == BURST_SAT) ? burst_cnt_reg
                                                                      : burst_cnt_reg + 1'b1;
                    end else begin
                        // Only a burst stopped by the length limit earns the CPU a guard window.
                        state_reg <= ST_RESUME;
                        cut_reg   <= vid_more;
                    end
                end
                ST_RESUME: begin
                    cpu_hold_reg <= 1'b0;
                    if (cut_reg) begin
                        state_reg     <= ST_GUARD;
                        guard_cnt_reg <= '0;
                    end else begin
                        state_reg     <= ST_CPU;
                    end
                end
                default: begin
                    cpu_hold_reg  <= 1'b0;
                    guard_cnt_reg <= (guard_cnt_reg == GUARD_SAT) ? guard_cnt_reg
                                                                  : guard_cnt_reg + 1'b1;
                    if (guard_cnt_reg == GUARD_LAST) begin
                        state_reg <= ST_CPU;
                    end
                end
            endcase
        end
    end

endmodule
